// File: rtl/fetch_queue_if.sv
// Fetch queue bus: memory fetch port, redirect, and the decode-side head port.
// Handshake: the head entry {outPc, outInst} transfers to decode on a cycle where
// outValid=1 and the decoder is ready (locker=0) and no redirect is requested
// (branchFlag=0); outValid never depends on locker within the same cycle.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetchAddr;
  logic [31:0]     instIn;
  logic            branchFlag;
  logic [XLEN-1:0] branchAddr;
  logic            locker;
  logic            outValid;
  logic [31:0]     outInst;
  logic [XLEN-1:0] outPc;
  logic [CW-1:0]   fillCount;
  logic            full;

  // Environment side: memory, branch unit and decoder.
  modport master (
    output instIn, branchFlag, branchAddr, locker,
    input  fetchAddr, outValid, outInst, outPc, fillCount, full
  );

  // Fetch queue side.
  modport slave (
    input  instIn, branchFlag, branchAddr, locker,
    output fetchAddr, outValid, outInst, outPc, fillCount, full
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches one word per cycle into a
// DEPTH-entry FIFO of {pc, inst}, and flushes/retargets on a branch redirect.
// Optional macro FQ_JAL_REDIRECT_EN: follow JAL targets at fetch time.
// Occupancy (EMPTY / PARTIAL / FULL) is derived from count_q; there is no FSM.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input logic         clk,
  input logic         resetIn,
  fetch_queue_if.slave fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_next;
  logic            is_empty, is_full, pop, push;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign pop      = !is_empty && !fq.locker && !fq.branchFlag;
  assign push     = !fq.branchFlag && (!is_full || pop);

`ifdef FQ_JAL_REDIRECT_EN
  logic            is_jal;
  logic [XLEN-1:0] j_imm;
  assign is_jal = (fq.instIn[6:0] == 7'b1101111);
  assign j_imm  = {{(XLEN-20){fq.instIn[31]}}, fq.instIn[19:12], fq.instIn[20],
                   fq.instIn[30:21], 1'b0};
  // Sequential fetch, or jump straight to the JAL target.
  always_comb begin
    pc_next = is_jal ? (pc_q + j_imm) : (pc_q + XLEN'(PC_STEP));
  end
`else
  // Sequential fetch only; the opcode is not inspected.
  always_comb begin
    pc_next = pc_q + XLEN'(PC_STEP);
  end
`endif

  // Next-state for pointers, count and PC; a redirect empties the queue.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    if (fq.branchFlag) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = fq.branchAddr;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_next;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state register; reset has priority over redirect and flow.
  always_ff @(posedge clk) begin
    if (resetIn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
    end
  end

  // Entry storage; written on push, never reset (count_q gates visibility).
  always_ff @(posedge clk) begin
    if (push && !resetIn) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      inst_mem_q[wr_ptr_q] <= fq.instIn;
    end
  end

  assign fq.fetchAddr = pc_q;
  assign fq.outValid  = !is_empty;
  assign fq.outInst   = is_empty ? 32'h0 : inst_mem_q[rd_ptr_q];
  assign fq.outPc     = is_empty ? '0 : pc_mem_q[rd_ptr_q];
  assign fq.fillCount = count_q;
  assign fq.full      = is_full;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a hand-written vector table, JAL sequence, and random
// traffic, all checked against a queue-based reference model every cycle.
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] JAL_W = 32'h0200006F; // jal x0, +0x20

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk     (clk),
    .resetIn (rst),
    .fq      (fq)
  );

  // Instruction memory: PC-tagged non-JAL words, optionally one JAL.
  logic        jal_en;
  logic [31:0] jal_pc;
  always_comb begin
    fq.instIn = (jal_en && fq.fetchAddr == jal_pc) ? JAL_W
                                                   : {fq.fetchAddr[24:0], 7'h13};
  end

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (jal_en && pc == jal_pc) ? JAL_W : {pc[24:0], 7'h13};
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [63:0] exp_q[$];   // {pc, inst} in fetch order
  logic [31:0] m_pc;
  bit          m_known = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge(input bit r, input bit b, input logic [31:0] ba, input bit l);
    bit          pop, push;
    logic [31:0] w;
    logic [31:0] imm;
    if (r) begin
      exp_q.delete(); m_pc = 32'h0; m_known = 1;
    end else if (b) begin
      exp_q.delete(); m_pc = ba;
    end else begin
      pop  = (exp_q.size() != 0) && !l;
      push = (exp_q.size() < DEPTH) || pop;
      w    = mem_word(m_pc);
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({m_pc, w});
        imm = 32'd4;
`ifdef FQ_JAL_REDIRECT_EN
        if (w[6:0] == 7'b1101111)
          imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
`endif
        m_pc = m_pc + imm;
      end
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive inputs, check outputs against the model, take the edge.
  task automatic drive_cycle(input bit r, input bit b, input logic [31:0] ba, input bit l);
    rst = r; fq.branchFlag = b; fq.branchAddr = ba; fq.locker = l;
    #1;
    if (m_known) begin
      chk("m_fetchAddr", fq.fetchAddr, m_pc);
      chk("m_outValid",  fq.outValid, exp_q.size() != 0);
      chk("m_outPc",     fq.outPc,   exp_q.size() != 0 ? exp_q[0][63:32] : 32'h0);
      chk("m_outInst",   fq.outInst, exp_q.size() != 0 ? exp_q[0][31:0]  : 32'h0);
      chk("m_fillCount", fq.fillCount, exp_q.size());
      chk("m_full",      fq.full, exp_q.size() == DEPTH);
    end
    @(posedge clk);
    model_edge(r, b, ba, l);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          r, b, l;
    logic [31:0] ba;
    bit          v;
    logic [31:0] pc;
    int          fill;
    logic [31:0] fetch;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit b, logic [31:0] ba, bit l,
                              bit v, logic [31:0] pc, int fill, logic [31:0] fetch);
    vec_t x;
    x.r = r; x.b = b; x.ba = ba; x.l = l; x.v = v; x.pc = pc; x.fill = fill; x.fetch = fetch;
    return x;
  endfunction

  logic [31:0] jal_next;

  initial begin
    rst = 1'b1; fq.branchFlag = 1'b0; fq.branchAddr = '0; fq.locker = 1'b0;
    jal_en = 1'b0; jal_pc = 32'h8;

    // Expected state after the edge of each row (DEPTH=4, step 4, reset PC 0).
    vecs.push_back(mk(1,0,0,0,   0,32'h0,  0,32'h0));
    vecs.push_back(mk(0,0,0,0,   1,32'h0,  1,32'h4));   // 1-cycle fetch-to-decode
    vecs.push_back(mk(0,0,0,0,   1,32'h4,  1,32'h8));
    vecs.push_back(mk(0,0,0,0,   1,32'h8,  1,32'hC));
    vecs.push_back(mk(1,0,0,0,   0,32'h0,  0,32'h0));
    vecs.push_back(mk(0,0,0,1,   1,32'h0,  1,32'h4));   // locked fill
    vecs.push_back(mk(0,0,0,1,   1,32'h0,  2,32'h8));
    vecs.push_back(mk(0,0,0,1,   1,32'h0,  3,32'hC));
    vecs.push_back(mk(0,0,0,1,   1,32'h0,  4,32'h10));
    vecs.push_back(mk(0,0,0,1,   1,32'h0,  4,32'h10));  // full: PC holds
    vecs.push_back(mk(0,0,0,1,   1,32'h0,  4,32'h10));
    vecs.push_back(mk(0,0,0,0,   1,32'h4,  4,32'h14));  // push+pop while full
    vecs.push_back(mk(0,0,0,0,   1,32'h8,  4,32'h18));
    vecs.push_back(mk(0,0,0,0,   1,32'hC,  4,32'h1C));
    vecs.push_back(mk(0,0,0,0,   1,32'h10, 4,32'h20));
    vecs.push_back(mk(1,0,0,0,   0,32'h0,  0,32'h0));
    vecs.push_back(mk(0,0,0,1,   1,32'h0,  1,32'h4));
    vecs.push_back(mk(0,0,0,1,   1,32'h0,  2,32'h8));
    vecs.push_back(mk(0,0,0,1,   1,32'h0,  3,32'hC));
    vecs.push_back(mk(0,1,32'h40,1, 0,32'h0, 0,32'h40));  // flush at fill 3
    vecs.push_back(mk(0,0,0,1,   1,32'h40, 1,32'h44));
    vecs.push_back(mk(0,0,0,1,   1,32'h40, 2,32'h48));
    vecs.push_back(mk(0,0,0,1,   1,32'h40, 3,32'h4C));
    vecs.push_back(mk(0,0,0,1,   1,32'h40, 4,32'h50));
    vecs.push_back(mk(0,1,32'h100,1, 0,32'h0, 0,32'h100)); // flush beats locker+full
    vecs.push_back(mk(0,0,0,0,   1,32'h100, 1,32'h104));
    vecs.push_back(mk(0,0,0,0,   1,32'h104, 1,32'h108));
    vecs.push_back(mk(0,0,0,1,   1,32'h104, 2,32'h10C));
    vecs.push_back(mk(1,0,0,1,   0,32'h0,  0,32'h0));     // reset discards 2 entries
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0, 0,32'h0, 0,32'hFFFF_FFFC));
    vecs.push_back(mk(0,0,0,0,   1,32'hFFFF_FFFC, 1,32'h0)); // silent PC wrap

    drive_cycle(1, 0, 0, 0);
    foreach (vecs[i]) begin
      drive_cycle(vecs[i].r, vecs[i].b, vecs[i].ba, vecs[i].l);
      chk($sformatf("t%0d_outValid", i), fq.outValid, vecs[i].v);
      chk($sformatf("t%0d_outPc", i), fq.outPc, vecs[i].pc);
      chk($sformatf("t%0d_outInst", i), fq.outInst,
          vecs[i].v ? {vecs[i].pc[24:0], 7'h13} : 32'h0);
      chk($sformatf("t%0d_fillCount", i), fq.fillCount, vecs[i].fill);
      chk($sformatf("t%0d_full", i), fq.full, vecs[i].fill == DEPTH);
      chk($sformatf("t%0d_fetchAddr", i), fq.fetchAddr, vecs[i].fetch);
    end

    // JAL at PC 0x8 with imm +0x20.
`ifdef FQ_JAL_REDIRECT_EN
    jal_next = 32'h28;
`else
    jal_next = 32'hC;
`endif
    drive_cycle(1, 0, 0, 0);
    jal_en = 1'b1;
    drive_cycle(0, 0, 0, 1);
    drive_cycle(0, 0, 0, 1);
    drive_cycle(0, 0, 0, 1);
    chk("jal_fetchAddr", fq.fetchAddr, jal_next);
    drive_cycle(0, 0, 0, 1);
    chk("jal_fill", fq.fillCount, 4);
    chk("jal_head0", fq.outPc, 32'h0);
    drive_cycle(0, 0, 0, 0);
    chk("jal_head1", fq.outPc, 32'h4);
    drive_cycle(0, 0, 0, 0);
    chk("jal_head2", fq.outPc, 32'h8);
    chk("jal_inst2", fq.outInst, JAL_W);
    drive_cycle(0, 0, 0, 0);
    chk("jal_head3", fq.outPc, jal_next);
    jal_en = 1'b0;

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive_cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) < 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single PC register and IF/ID latch pair. It owns the PC and drives the combinational instruction memory address. Fetched {pc, inst} pairs are buffered in a DEPTH-entry FIFO, so fetch keeps running while decode is locked. A branch redirect flushes the FIFO and retargets the PC.

Parameters:
XLEN, 32, PC and address width
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  clock, all state on rising edge
resetIn  in  1  synchronous active-high reset
fetchAddr  out  XLEN  address to instruction memory (equals PC register)
instIn  in  32  instruction from memory, combinational from fetchAddr, same cycle
branchFlag  in  1  redirect request from branch unit
branchAddr  in  XLEN  redirect target
locker  in  1  decode stall; head entry must not be consumed
outValid  out  1  head entry valid for decode
outInst  out  32  head instruction; 0 when empty
outPc  out  XLEN  head PC; 0 when empty
fillCount  out  $clog2(DEPTH)+1  occupied entries
full  out  1  fillCount == DEPTH

Behaviour:
- Reset (resetIn=1 at edge):
  - PC=RESET_PC, read/write pointers=0, count=0.
  - outValid=0, outInst=0, outPc=0, fillCount=0, full=0.
  - Reset has priority over everything. Asserting it mid-operation discards all entries.
- pop = outValid && !locker && !branchFlag.
- push = !branchFlag && (!full || pop).
  - A push while full is allowed only when a pop occurs in the same cycle.
- Push: at the edge, write {PC, instIn} at the write pointer, advance the pointer, PC <= PC + PC_STEP.
- No push: PC holds.
- Pop: advance the read pointer.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Pointers are log2(DEPTH) bits and wrap naturally.
- PC arithmetic is modulo 2^XLEN; wrap from all-ones is silent.
- outValid = (count != 0).
- Head outputs are combinational from the read pointer entry, forced to 0 when empty.
- Redirect (branchFlag=1 at edge, resetIn=0):
  - Pointers=0, count=0, PC <= branchAddr.
  - No push or pop that cycle, regardless of locker or full.
  - Redirect beats locker.
- Latency:
  - Fetch to decode is 1 cycle: an entry pushed at edge N is visible at outValid after edge N when the FIFO was empty.
  - Redirect costs a 2-cycle bubble:
    - Edge R: flush.
    - Cycle after R: fetchAddr=target, outValid=0.
    - Edge R+1: target pushed.
    - Cycle after R+1: outValid=1, outPc=target.
- Ordering: entries leave strictly in fetch order. No entry may be duplicated or dropped except by flush or reset.
- No state machine beyond the FIFO counters. States are implicitly EMPTY / PARTIAL / FULL, derived from count.

Optional Feature:
FQ_JAL_REDIRECT_EN
- Defined: when a push occurs and instIn[6:0]==7'b1101111 (JAL), the next PC is PC + sign-extended J-immediate instead of PC + PC_STEP.
  - J-immediate is {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - The JAL entry is still enqueued unchanged.
  - branchFlag and resetIn still override.
- Undefined: all pushes advance PC by PC_STEP. Opcode is not inspected.

Test Plan:
- Reset, then release with locker=0 and memory returning PC-tagged words -> the cycle after the first edge shows outValid=1, outPc=0, fetchAddr=0x4. Then one pop and one push per cycle, fillCount steady at 1.
- locker=1 for 6 cycles, DEPTH=4 -> fillCount reaches 4, full=1, fetchAddr holds at 0x10. Release locker -> outPc sequence 0x0,0x4,0x8,0xC,0x10, with simultaneous push/pop keeping fillCount=4 on the first release cycle.
- fillCount=3, branchFlag=1, branchAddr=0x40 -> next cycle fillCount=0, outValid=0, fetchAddr=0x40. Cycle after: outValid=1, outPc=0x40, fetchAddr=0x44.
- branchFlag=1 with locker=1 and full=1 simultaneously -> flush wins: fillCount=0, fetchAddr=target, no stale entry ever appears on outPc.
- resetIn=1 for one edge while fillCount=2 -> fillCount=0, outValid=0, outInst=0, fetchAddr=RESET_PC on the next cycle.
- FQ_JAL_REDIRECT_EN defined, JAL imm=+0x20 at PC 0x8 -> fetchAddr becomes 0x28 after the push, and the queue holds outPc 0x8 followed by 0x28. With the macro undefined -> fetchAddr 0xC.
